// File: rtl/universal_shift_register.sv
// universal_shift_register
// WIDTH-bit universal shift register: hold, shift right, shift left and
// parallel load under direct Mode control, plus a burst sequencer that
// shifts Count positions autonomously with a Busy/Done handshake.
//
// Optional feature macro: USR_ROTATE_EN
//   defined   -> a burst latched with Rotate=1 recirculates bits (rotate)
//   undefined -> Rotate is ignored and every burst is a plain serial shift
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [1:0]       Mode,
  input  logic             Sin_R,
  input  logic             Sin_L,
  input  logic [WIDTH-1:0] Pin,
  input  logic             Start,
  input  logic             Dir,
  input  logic [CW-1:0]    Count,
  input  logic             Rotate,
  output logic [WIDTH-1:0] Pout,
  output logic             Sout_R,
  output logic             Sout_L,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_CW   = CW'(1);
  localparam logic [CW-1:0] ZERO_CW  = {CW{1'b0}};

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic [CW-1:0]    rem_r;
  logic [CW-1:0]    rem_next_s;
  logic [CW-1:0]    count_clamped_s;
  logic             dir_r;
  logic             dir_next_s;
  logic             busy_r;
  logic             done_r;
  logic             right_fill_s;
  logic             left_fill_s;

  // Shift one position toward bit 0, new bit enters at the MSB.
  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] q,
                                                   input logic             fill);
    shift_right = {fill, q[WIDTH-1:1]};
  endfunction

  // Shift one position toward the MSB, new bit enters at bit 0.
  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] q,
                                                  input logic             fill);
    shift_left = {q[WIDTH-2:0], fill};
  endfunction

  // Clamp an oversized burst count to a full-width shift.
  always_comb begin
    count_clamped_s = Count;
    if (Count > WIDTH_CW) begin
      count_clamped_s = WIDTH_CW;
    end else begin
      count_clamped_s = Count;
    end
  end

`ifdef USR_ROTATE_EN
  logic rot_r;
  logic rot_next_s;

  // Burst fill bits: recirculate the far end of Q when rotating, else live serial inputs.
  always_comb begin
    right_fill_s = Sin_R;
    left_fill_s  = Sin_L;
    if (rot_r) begin
      right_fill_s = q_r[0];
      left_fill_s  = q_r[WIDTH-1];
    end else begin
      right_fill_s = Sin_R;
      left_fill_s  = Sin_L;
    end
  end

  // Rotate select is captured only when a burst is accepted.
  always_comb begin
    rot_next_s = rot_r;
    if ((state_r == ST_IDLE) && Start) begin
      rot_next_s = Rotate;
    end else begin
      rot_next_s = rot_r;
    end
  end

  // Latched rotate select for the burst in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rot_r <= 1'b0;
    end else begin
      rot_r <= rot_next_s;
    end
  end
`else
  logic unused_rotate_s;
  assign unused_rotate_s = Rotate;
  assign right_fill_s    = Sin_R;
  assign left_fill_s     = Sin_L;
`endif

  // Next-state, next-Q and burst bookkeeping for the sequencer and direct modes.
  always_comb begin
    state_next_s = state_r;
    q_next_s     = q_r;
    rem_next_s   = rem_r;
    dir_next_s   = dir_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          // Start wins over direct control; Q is left alone this cycle.
          rem_next_s = count_clamped_s;
          dir_next_s = Dir;
          if (count_clamped_s != ZERO_CW) begin
            state_next_s = ST_SHIFT;
          end else begin
            state_next_s = ST_DONE;
          end
        end else if (Enable) begin
          case (Mode)
            2'b00:   q_next_s = q_r;
            2'b01:   q_next_s = shift_right(q_r, Sin_R);
            2'b10:   q_next_s = shift_left(q_r, Sin_L);
            2'b11:   q_next_s = Pin;
            default: q_next_s = q_r;
          endcase
        end else begin
          q_next_s = q_r;
        end
      end
      ST_SHIFT: begin
        if (dir_r) begin
          q_next_s = shift_left(q_r, left_fill_s);
        end else begin
          q_next_s = shift_right(q_r, right_fill_s);
        end
        rem_next_s = rem_r - ONE_CW;
        // A zero remainder here can only come from corruption; end the burst.
        if (rem_r <= ONE_CW) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        q_next_s     = q_r;
        rem_next_s   = ZERO_CW;
      end
    endcase
  end

  // State, data and handshake registers; Busy/Done are registered from next state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      q_r     <= {WIDTH{1'b0}};
      rem_r   <= ZERO_CW;
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      q_r     <= q_next_s;
      rem_r   <= rem_next_s;
      dir_r   <= dir_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  assign Pout   = q_r;
  assign Sout_R = q_r[0];
  assign Sout_L = q_r[WIDTH-1];
  assign Busy   = busy_r;
  assign Done   = done_r;

endmodule
